// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ALU opcodes, forwarding selects and multiplier FSM state for the MIPS pipeline
package pipeline_pkg;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_NOR = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   localparam logic [1:0] FWD_NONE  = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_e;

   // The younger EX/MEM result shadows MEM/WB; $0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic exm_we, input logic [4:0] exm_rd,
                                          input logic wb_we, input logic [4:0] wb_rd);
      return (exm_we && exm_rd != 5'd0 && exm_rd == src) ? FWD_EXMEM :
             (wb_we && wb_rd != 5'd0 && wb_rd == src) ? FWD_MEMWB : FWD_NONE;
   endfunction
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
module ex_mul_seq
   import pipeline_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(MUL_CYCLES + 1);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (abort) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d  = S_MUL;
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
            end
            S_MUL: begin
               acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy    = state_q == S_MUL || (state_q == S_IDLE && start && !abort);
   assign done    = state_q == S_DONE;
   assign product = acc_q;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX stage with forwarding, single-cycle ALU, iterative multiply and the EX/MEM register.
module ex_mem_stage
   import pipeline_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ID_EX_rs_content,
   input  logic [WIDTH-1:0] ID_EX_rt_content,
   input  logic [WIDTH-1:0] ID_EX_immediate,
   input  logic [4:0]       ID_EX_rs,
   input  logic [4:0]       ID_EX_rt,
   input  logic [4:0]       ID_EX_rd,
   input  logic [2:0]       ID_EX_ALUop,
   input  logic             ID_EX_ALUsrc,
   input  logic             ID_EX_dst,
   input  logic             ID_EX_memread,
   input  logic             ID_EX_memwrite,
   input  logic             ID_EX_memtoreg,
   input  logic             ID_EX_regwrite,
   input  logic             MEM_WB_regwrite,
   input  logic [4:0]       MEM_WB_rd,
   input  logic [WIDTH-1:0] MEM_WB_write_data,
   input  logic             flush,
   output logic [WIDTH-1:0] EX_MEM_alu_result,
   output logic [WIDTH-1:0] EX_MEM_store_data,
   output logic [4:0]       EX_MEM_rd,
   output logic             EX_MEM_memread,
   output logic             EX_MEM_memwrite,
   output logic             EX_MEM_memtoreg,
   output logic             EX_MEM_regwrite,
   output logic             ex_busy
);
   logic [1:0]       sel_a, sel_b;
   logic [WIDTH-1:0] op_a, fwd_b, op_b, alu_y, product;
   logic             busy, done;
   logic [WIDTH-1:0] alu_q, alu_d, store_q, store_d;
   logic [4:0]       rd_q, rd_d;
   logic             mr_q, mr_d, mw_q, mw_d, mt_q, mt_d, rw_q, rw_d;

   assign sel_a = fwd_sel(ID_EX_rs, rw_q, rd_q, MEM_WB_regwrite, MEM_WB_rd);
   assign sel_b = fwd_sel(ID_EX_rt, rw_q, rd_q, MEM_WB_regwrite, MEM_WB_rd);
   assign op_a  = sel_a == FWD_EXMEM ? alu_q : sel_a == FWD_MEMWB ? MEM_WB_write_data : ID_EX_rs_content;
   assign fwd_b = sel_b == FWD_EXMEM ? alu_q : sel_b == FWD_MEMWB ? MEM_WB_write_data : ID_EX_rt_content;
   assign op_b  = ID_EX_ALUsrc ? ID_EX_immediate : fwd_b;

   always_comb begin
      alu_y = '0;
      case (ID_EX_ALUop)
         ALU_ADD: alu_y = op_a + op_b;
         ALU_SUB: alu_y = op_a - op_b;
         ALU_AND: alu_y = op_a & op_b;
         ALU_OR:  alu_y = op_a | op_b;
         ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_XOR: alu_y = op_a ^ op_b;
         ALU_NOR: alu_y = ~(op_a | op_b);
         default: alu_y = '0;
      endcase
   end

   ex_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (ID_EX_ALUop == ALU_MUL && ID_EX_regwrite),
      .abort   (flush),
      .a       (op_a),
      .b       (fwd_b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Bubble while flushing or while the multiplier owns the stage; DONE retires the held mul.
   always_comb begin
      alu_d   = '0;
      store_d = '0;
      rd_d    = '0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      mt_d    = 1'b0;
      rw_d    = 1'b0;
      if (!(flush || busy)) begin
         alu_d   = done ? product : alu_y;
         store_d = fwd_b;
         rd_d    = ID_EX_dst ? ID_EX_rd : ID_EX_rt;
         mr_d    = ID_EX_memread;
         mw_d    = ID_EX_memwrite;
         mt_d    = ID_EX_memtoreg;
         rw_d    = ID_EX_regwrite;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q   <= '0;
         store_q <= '0;
         rd_q    <= '0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         mt_q    <= 1'b0;
         rw_q    <= 1'b0;
      end else begin
         alu_q   <= alu_d;
         store_q <= store_d;
         rd_q    <= rd_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         mt_q    <= mt_d;
         rw_q    <= rw_d;
      end
   end

   assign EX_MEM_alu_result = alu_q;
   assign EX_MEM_store_data = store_q;
   assign EX_MEM_rd         = rd_q;
   assign EX_MEM_memread    = mr_q;
   assign EX_MEM_memwrite   = mw_q;
   assign EX_MEM_memtoreg   = mt_q;
   assign EX_MEM_regwrite   = rw_q;
   assign ex_busy           = busy;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with hand-computed expectations for ex_mem_stage.
module tb_ex_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rs_content, rt_content, immediate;
   logic [4:0]  rs, rt, rd;
   logic [2:0]  aluop;
   logic        alusrc, dst, memread, memwrite, memtoreg, regwrite;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic [31:0] alu_result, store_data;
   logic [4:0]  exm_rd;
   logic        exm_memread, exm_memwrite, exm_memtoreg, exm_regwrite, ex_busy;
   int          passed = 0;
   int          total  = 0;
   int          busy_n, bub_n, wr_n;

   always #5 clk = ~clk;

   ex_mem_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ID_EX_rs_content  (rs_content),
      .ID_EX_rt_content  (rt_content),
      .ID_EX_immediate   (immediate),
      .ID_EX_rs          (rs),
      .ID_EX_rt          (rt),
      .ID_EX_rd          (rd),
      .ID_EX_ALUop       (aluop),
      .ID_EX_ALUsrc      (alusrc),
      .ID_EX_dst         (dst),
      .ID_EX_memread     (memread),
      .ID_EX_memwrite    (memwrite),
      .ID_EX_memtoreg    (memtoreg),
      .ID_EX_regwrite    (regwrite),
      .MEM_WB_regwrite   (wb_regwrite),
      .MEM_WB_rd         (wb_rd),
      .MEM_WB_write_data (wb_data),
      .flush             (flush),
      .EX_MEM_alu_result (alu_result),
      .EX_MEM_store_data (store_data),
      .EX_MEM_rd         (exm_rd),
      .EX_MEM_memread    (exm_memread),
      .EX_MEM_memwrite   (exm_memwrite),
      .EX_MEM_memtoreg   (exm_memtoreg),
      .EX_MEM_regwrite   (exm_regwrite),
      .ex_busy           (ex_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic ins(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] b, input logic ds, input logic rw);
      aluop = op; rs = s; rt = t; rd = d; rs_content = a; rt_content = b; dst = ds; regwrite = rw;
      alusrc = 1'b0; immediate = '0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".alu"}, alu_result, 32'h0);
      chk({tag, ".store"}, store_data, 32'h0);
      chk({tag, ".rd"}, {27'd0, exm_rd}, 32'h0);
      chk({tag, ".ctl"}, {28'd0, exm_memread, exm_memwrite, exm_memtoreg, exm_regwrite}, 32'h0);
      chk({tag, ".busy"}, {31'd0, ex_busy}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
      ins(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst_n = 1'b1;

      ins(3'b000, 5'd2, 5'd3, 5'd4, 32'd2, 32'd3, 1'b1, 1'b1);
      step;
      chk("add2+3", alu_result, 32'd5);
      chk("add2+3.rd", {27'd0, exm_rd}, 32'd4);
      chk("add2+3.rw", {31'd0, exm_regwrite}, 32'd1);

      ins(3'b000, 5'd2, 5'd0, 5'd1, 32'h10, 32'h0, 1'b1, 1'b1);
      step;
      chk("setup$1", alu_result, 32'h10);

      ins(3'b000, 5'd1, 5'd1, 5'd0, 32'h5, 32'h5, 1'b1, 1'b1);
      wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'h99;
      step;
      chk("fwd_exmem_wins", alu_result, 32'h20);
      step;
      chk("fwd_memwb_rd0", alu_result, 32'h132);
      wb_regwrite = 1'b0;

      ins(3'b100, 5'd5, 5'd6, 5'd7, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
      step;
      chk("slt_neg", alu_result, 32'd1);
      ins(3'b001, 5'd8, 5'd9, 5'd10, 32'd0, 32'd1, 1'b1, 1'b1);
      step;
      chk("sub0-1", alu_result, 32'hFFFF_FFFF);
      ins(3'b110, 5'd11, 5'd12, 5'd13, 32'd0, 32'd0, 1'b1, 1'b1);
      step;
      chk("nor00", alu_result, 32'hFFFF_FFFF);
      ins(3'b101, 5'd11, 5'd12, 5'd13, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b1);
      step;
      chk("xor", alu_result, 32'h0000_0FF0);
      ins(3'b010, 5'd11, 5'd12, 5'd13, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b1);
      step;
      chk("and", alu_result, 32'h0000_F000);

      ins(3'b000, 5'd14, 5'd15, 5'd0, 32'h100, 32'h0, 1'b0, 1'b0);
      alusrc = 1'b1; immediate = 32'd8; memwrite = 1'b1;
      wb_regwrite = 1'b1; wb_rd = 5'd15; wb_data = 32'hABCD;
      step;
      chk("sw.addr", alu_result, 32'h108);
      chk("sw.data", store_data, 32'hABCD);
      chk("sw.ctl", {28'd0, exm_memread, exm_memwrite, exm_memtoreg, exm_regwrite}, 32'b0100);
      chk("sw.rd", {27'd0, exm_rd}, 32'd15);
      wb_regwrite = 1'b0;

      ins(3'b111, 5'd16, 5'd17, 5'd18, 32'h0001_0003, 32'h0000_0005, 1'b1, 1'b1);
      #1;
      chk("mul.start_busy", {31'd0, ex_busy}, 32'd1);
      busy_n = 0; bub_n = 0;
      for (int i = 0; i < 60 && ex_busy; i++) begin
         busy_n++;
         if (i == 5) begin
            wb_regwrite = 1'b1; wb_rd = 5'd16; wb_data = 32'hDEAD_BEEF;
         end
         step;
         if ({exm_memread, exm_memwrite, exm_memtoreg, exm_regwrite} == 4'b0 && alu_result == 32'h0) bub_n++;
      end
      wb_regwrite = 1'b0;
      chk("mul.busy_cycles", busy_n, 32'd33);
      chk("mul.bubbles", bub_n, 32'd33);
      chk("mul.done_not_busy", {31'd0, ex_busy}, 32'd0);
      step;
      chk("mul.product", alu_result, 32'h0005_000F);
      chk("mul.rd", {27'd0, exm_rd}, 32'd18);
      chk("mul.rw", {31'd0, exm_regwrite}, 32'd1);

      ins(3'b000, 5'd18, 5'd20, 5'd19, 32'h0, 32'd1, 1'b1, 1'b1);
      #1;
      chk("b2b.busy", {31'd0, ex_busy}, 32'd0);
      step;
      chk("b2b.fwd_product", alu_result, 32'h0005_0010);

      ins(3'b111, 5'd21, 5'd22, 5'd23, 32'd7, 32'd9, 1'b1, 1'b1);
      repeat (11) step;
      flush = 1'b1;
      #1;
      chk("flush.busy_in_mul", {31'd0, ex_busy}, 32'd1);
      step;
      flush = 1'b0;
      ins(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("flush.bubble", {31'd0, exm_regwrite}, 32'd0);
      chk("flush.busy_dropped", {31'd0, ex_busy}, 32'd0);
      busy_n = 0; wr_n = 0;
      for (int i = 0; i < 40; i++) begin
         step;
         if (ex_busy) busy_n++;
         if (exm_regwrite || alu_result == 32'd63) wr_n++;
      end
      chk("flush.no_product", wr_n, 32'd0);
      chk("flush.stays_idle", busy_n, 32'd0);

      ins(3'b111, 5'd21, 5'd22, 5'd23, 32'd7, 32'd9, 1'b1, 1'b1);
      flush = 1'b1;
      #1;
      chk("flush_start.busy", {31'd0, ex_busy}, 32'd0);
      step;
      chk("flush_start.bubble", {31'd0, exm_regwrite}, 32'd0);
      flush = 1'b0;
      ins(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("flush_start.idle", {31'd0, ex_busy}, 32'd0);

      ins(3'b000, 5'd2, 5'd3, 5'd4, 32'd2, 32'd3, 1'b1, 1'b1);
      flush = 1'b1;
      step;
      chk("flush_add.rw", {31'd0, exm_regwrite}, 32'd0);
      chk("flush_add.alu", alu_result, 32'd0);
      flush = 1'b0;

      ins(3'b111, 5'd24, 5'd25, 5'd26, 32'd3, 32'd4, 1'b1, 1'b1);
      repeat (5) step;
      chk("rstmid.busy", {31'd0, ex_busy}, 32'd1);
      rst_n = 1'b0;
      ins(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_idle_outputs("rstmid");
      step;
      rst_n = 1'b1;
      ins(3'b000, 5'd2, 5'd3, 5'd4, 32'd2, 32'd3, 1'b1, 1'b1);
      #1;
      chk("rstmid.idle", {31'd0, ex_busy}, 32'd0);
      step;
      chk("rstmid.add", alu_result, 32'd5);
      chk("rstmid.rw", {31'd0, exm_regwrite}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
